// File: rtl/result_collector.sv
// Receive-side result collector: gathers NUM items per batch over valid/ready,
// keeps a running checksum and toggles rcv_en_o on every completed batch.
//   state   | meaning
//   IDLE    | not collecting; partial batch contents retained
//   COLLECT | accepting items, res_ready_o high
//   FULL    | batch complete, back-pressure until batch_ack_i
module result_collector #(
  parameter  int NUM        = 100,
  parameter  int ITEM_WIDTH = 8,
  localparam int CNT_W      = $clog2(NUM + 1),
  localparam int CSUM_W     = ITEM_WIDTH + $clog2(NUM)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  res_valid_i,
  input  logic [ITEM_WIDTH-1:0] res_i,
  output logic                  res_ready_o,
  input  logic                  batch_ack_i,
  output logic [ITEM_WIDTH-1:0] res_data_o [NUM-1:0],
  output logic [CNT_W-1:0]      count_o,
  output logic [CSUM_W-1:0]     checksum_o,
  output logic                  rcv_en_o,
  output logic [15:0]           batch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic accept;
  logic last_accept;
  logic batch_start;

  assign res_ready_o = (state_q == COLLECT);
  assign accept      = res_valid_i && res_ready_o;
  assign last_accept = accept && (count_o == CNT_W'(NUM - 1));
  // Counters restart whenever a new batch window opens, not when one closes.
  assign batch_start = ((state_q == IDLE) && enable_i) ||
                       ((state_q == FULL) && batch_ack_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = COLLECT;
      end
      COLLECT: begin
        if (last_accept)    state_d = FULL;
        else if (!enable_i) state_d = IDLE;
      end
      FULL: begin
        if (batch_ack_i) state_d = enable_i ? COLLECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o     <= '0;
      checksum_o  <= '0;
      rcv_en_o    <= 1'b0;
      batch_cnt_o <= '0;
      for (int i = 0; i < NUM; i++) res_data_o[i] <= '0;
    end else if (batch_start) begin
      count_o    <= '0;
      checksum_o <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM; i++) begin
        if (count_o == CNT_W'(i)) res_data_o[i] <= res_i;
      end
      count_o    <= count_o + CNT_W'(1);
      checksum_o <= checksum_o + CSUM_W'(res_i);
      if (last_accept) begin
        rcv_en_o    <= ~rcv_en_o;
        batch_cnt_o <= batch_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (NUM=4): accepted items go to a scoreboard
// queue and are popped against the result array once the batch is visible.
module tb_result_collector;

  localparam int NUM    = 4;
  localparam int IW     = 8;
  localparam int CNT_W  = $clog2(NUM + 1);
  localparam int CSUM_W = IW + $clog2(NUM);

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              enable_i = 1'b0;
  logic              res_valid_i = 1'b0;
  logic [IW-1:0]     res_i = '0;
  logic              res_ready_o;
  logic              batch_ack_i = 1'b0;
  logic [IW-1:0]     res_data_o [NUM-1:0];
  logic [CNT_W-1:0]  count_o;
  logic [CSUM_W-1:0] checksum_o;
  logic              rcv_en_o;
  logic [15:0]       batch_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [IW-1:0] sb [$];
  int exp_sum;

  result_collector #(.NUM(NUM), .ITEM_WIDTH(IW)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .res_ready_o (res_ready_o),
    .batch_ack_i (batch_ack_i),
    .res_data_o  (res_data_o),
    .count_o     (count_o),
    .checksum_o  (checksum_o),
    .rcv_en_o    (rcv_en_o),
    .batch_cnt_o (batch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one item and hold it until the collector takes it (bounded).
  task automatic send(input logic [IW-1:0] v);
    int waited;
    res_valid_i = 1'b1;
    res_i       = v;
    waited      = 0;
    while (!res_ready_o && waited < 8) begin
      tick();
      waited++;
    end
    if (!res_ready_o) begin
      n_cmp++;
      n_fail++;
      $error("FAIL send_timeout: observed ready=0 expected ready=1 for item %0h", v);
      res_valid_i = 1'b0;
      return;
    end
    tick();
    sb.push_back(v);
    exp_sum += int'(v);
  endtask

  task automatic check_batch(input string tag);
    for (int i = 0; i < NUM; i++) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL %s_sb_empty: observed empty expected item %0d", tag, i);
      end else begin
        check(tag, res_data_o[i], sb.pop_front());
      end
    end
  endtask

  task automatic pulse_ack();
    batch_ack_i = 1'b1;
    tick();
    batch_ack_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. asynchronous reset between edges, then idle with enable low
    #2 reset_i = 1'b1;
    #1;
    check("rst_ready", res_ready_o, 0);
    check("rst_count", count_o, 0);
    check("rst_csum", checksum_o, 0);
    check("rst_rcv_en", rcv_en_o, 0);
    check("rst_bcnt", batch_cnt_o, 0);
    for (int i = 0; i < NUM; i++) check("rst_data", res_data_o[i], 0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    check("idle_ready", res_ready_o, 0);

    // 2. single batch 1..4
    enable_i = 1'b1;
    tick();
    check("entry_ready", res_ready_o, 1);
    exp_sum = 0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    res_valid_i = 1'b0;
    check("b1_ready", res_ready_o, 0);
    check("b1_count", count_o, NUM);
    check("b1_csum", checksum_o, exp_sum);
    check("b1_rcv_en", rcv_en_o, 1);
    check("b1_bcnt", batch_cnt_o, 1);
    check_batch("b1_data");

    // 4. ack and 0xFF batch
    pulse_ack();
    check("ack_ready", res_ready_o, 1);
    check("ack_count", count_o, 0);
    check("ack_csum", checksum_o, 0);
    exp_sum = 0;
    for (int i = 0; i < NUM; i++) send(8'hFF);
    res_valid_i = 1'b0;
    check("b2_csum", checksum_o, 32'h3FC);
    check("b2_csum_model", checksum_o, exp_sum);
    check("b2_rcv_en", rcv_en_o, 0);
    check("b2_bcnt", batch_cnt_o, 2);
    check_batch("b2_data");

    // 3. valid gap, then back-pressure while FULL
    pulse_ack();
    exp_sum = 0;
    send(8'd5);
    res_valid_i = 1'b0;
    tick();
    check("gap_count", count_o, 1);
    send(8'd6); send(8'd7); send(8'd8);
    res_i = 8'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", res_ready_o, 0);
      check("bp_count", count_o, NUM);
    end
    res_valid_i = 1'b0;
    check("b3_csum", checksum_o, 26);
    check("b3_csum_model", checksum_o, exp_sum);
    check("b3_bcnt", batch_cnt_o, 3);
    check("b3_rcv_en", rcv_en_o, 1);
    check_batch("b3_data");

    // 5. enable dropped together with the 2nd accept
    pulse_ack();
    check("b4_ready", res_ready_o, 1);
    exp_sum = 0;
    send(8'h11);
    res_valid_i = 1'b1;
    res_i       = 8'h22;
    enable_i    = 1'b0;
    tick();
    res_valid_i = 1'b0;
    sb.push_back(8'h22);
    exp_sum += 'h22;
    check("drop_ready", res_ready_o, 0);
    check("drop_count", count_o, 2);
    check("drop_csum", checksum_o, exp_sum);
    pulse_ack();
    check("ign_ack_count", count_o, 2);
    check("ign_ack_ready", res_ready_o, 0);
    check("drop_data0", res_data_o[0], sb.pop_front());
    check("drop_data1", res_data_o[1], sb.pop_front());
    enable_i = 1'b1;
    tick();
    check("reen_count", count_o, 0);
    check("reen_csum", checksum_o, 0);
    check("reen_ready", res_ready_o, 1);
    check("reen_data0", res_data_o[0], 8'h11);

    // 6. reset after 3 accepts, asserted between edges
    send(8'd1); send(8'd2); send(8'd3);
    res_valid_i = 1'b0;
    check("pre_rst_count", count_o, 3);
    #2 reset_i = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_count", count_o, 0);
    check("mid_rst_csum", checksum_o, 0);
    check("mid_rst_rcv_en", rcv_en_o, 0);
    check("mid_rst_bcnt", batch_cnt_o, 0);
    check("mid_rst_ready", res_ready_o, 0);
    for (int i = 0; i < NUM; i++) check("mid_rst_data", res_data_o[i], 0);
    enable_i = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    check("post_rst_ready", res_ready_o, 0);
    enable_i = 1'b1;
    tick();
    check("resume_ready", res_ready_o, 1);
    check("resume_count", count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
